pe_conv_mac_sched: RTL and testbench
====================================

Name: pe_conv_mac_sched

Overview:
- Sequencer for the conv PE input-buffer/MAC datapath.
- Accepts one receptive-field window per handshake and pulses `load` so the buffer captures it.
- Steps the buffer `pixel` select through all K*K kernel positions for every input-channel group, driving `buf_en`.
- Emits MAC first/last markers aligned to buffer output, then holds a result handshake until downstream accepts.

Parameters:
- pKERNEL_SIZE, 3: kernel edge; a window is K*K pixels.
- pINPUT_CHANNEL, 1: total input channels.
- pINPUT_PARALLEL, 1: channels processed per beat. G = pINPUT_CHANNEL/pINPUT_PARALLEL groups; must divide evenly.
- pPIPE_LAT, 2: cycles from `pixel`/`buf_en` issue to buffer `data_out`/`valid`.

Ports:
- clk, input, 1: clock; all state on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- win_valid, input, 1: upstream window available.
- win_ready, output, 1: sequencer can accept a window.
- load, output, 1: one-cycle pulse; buffer captures `data_in` this cycle.
- buf_en, output, 1: issue beat to buffer.
- pixel, output, $clog2(pKERNEL_SIZE*pKERNEL_SIZE): kernel position select.
- chgrp, output, max(1,$clog2(G)): current channel group.
- mac_first, output, 1: first product of window, aligned to buffer `valid` (issue + pPIPE_LAT).
- mac_last, output, 1: last product of window, same alignment.
- result_valid, output, 1: accumulation complete; held until accepted.
- result_ready, input, 1: downstream accepts result.
- busy, output, 1: high in any state but IDLE.
- perf_stall_cnt, output, 32: see Optional Feature.

Behaviour:
- Reset (async assert, sync release) values: state IDLE, all counters 0, delay lines cleared. All outputs 0 except `win_ready`=1.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - `win_ready`=1.
  - `win_valid`&`win_ready` -> LOAD.
- LOAD:
  - `load`=1 for exactly one cycle; `win_ready`=0.
  - Next state RUN, with pixel=0 and chgrp=0.
- RUN:
  - `buf_en`=1 every cycle.
  - `pixel` increments 0..K*K-1, wrapping to 0 and incrementing `chgrp`. `pixel` is the inner loop, `chgrp` the outer.
  - Total T = K*K*G beats with no bubbles.
  - The beat at pixel=K*K-1, chgrp=G-1 is the last; next state DRAIN.
- Alignment shift registers (depth pPIPE_LAT):
  - `first_iss` is high on beat 0; `last_iss` is high on beat T-1.
  - Both are shifted pPIPE_LAT cycles to produce `mac_first`/`mac_last`.
  - If T=1, both markers are high on the same cycle.
- DRAIN:
  - `buf_en`=0; `pixel`/`chgrp` hold 0.
  - Wait until `mac_last` has been emitted (pPIPE_LAT cycles after the last beat) -> DONE.
- DONE:
  - `result_valid`=1, held stable while `result_ready`=0.
  - On `result_ready`=1: `result_valid` drops next cycle -> IDLE.
- Latency:
  - Window accept edge to first `buf_en`: 2 cycles.
  - `win_ready` re-asserts T+pPIPE_LAT+3 cycles after accept, assuming `result_ready` is held high.
  - Throughput is one window per T+pPIPE_LAT+3 cycles; there is no overlap.
- `win_valid` deasserted mid-window: ignored; the window is already captured.
- `result_ready` high before DONE: ignored; no early completion.
- Reset mid-window:
  - Immediate abort to IDLE.
  - Delay lines cleared, so no stray `mac_first`/`mac_last`/`result_valid` after release.
- Counter widths: `pixel` counter width = port width; it must never reach K*K.

Optional Feature:
- Macro: PE_CONV_MAC_SCHED_PERF_EN.
- Defined:
  - `perf_stall_cnt` counts cycles in DONE with `result_ready`=0.
  - Saturates at 2^32-1; cleared only by reset.
- Undefined:
  - Counter logic omitted; `perf_stall_cnt` tied to 0.
  - All other behaviour is identical.

Test Plan:
- Default params (K=3, G=1, LAT=2), `result_ready`=1, one window:
  - `load` one cycle after accept.
  - `pixel` 0..8 over 9 consecutive `buf_en` cycles.
  - `mac_first` 2 cycles after `pixel`=0; `mac_last` 2 cycles after `pixel`=8.
  - `result_valid` one cycle; `win_ready` back 14 cycles after accept.
- pINPUT_CHANNEL=4, pINPUT_PARALLEL=2 (G=2):
  - `pixel` runs 0..8 twice, with `chgrp` 0 then 1.
  - 18 `buf_en` cycles; exactly one `mac_first` and one `mac_last`.
- `result_ready` held 0 for 5 cycles in DONE:
  - `result_valid` stays 1 and `win_ready` stays 0.
  - With PERF_EN, `perf_stall_cnt`=5.
- Back-to-back windows, `win_valid` always 1:
  - Second accept only when `win_ready`=1.
  - `mac_first`/`mac_last` pairs never interleave.
- `rst_n` asserted at RUN beat 4:
  - All outputs reset asynchronously; `win_ready`=1 after release.
  - No `mac_last` or `result_valid` appears afterwards.
- K=1, G=1 (T=1):
  - `mac_first` and `mac_last` high on the same cycle.
  - `pixel` width 1 and held at 0.

Source files
------------

// File: rtl/pe_conv_mac_sched.sv
// Window sequencer for the conv PE input buffer and MAC: load, kernel/channel-group sweep, marker alignment, result handshake.
// Optional stall counter enabled by defining PE_CONV_MAC_SCHED_PERF_EN.
module pe_conv_mac_sched #(
  parameter int pKERNEL_SIZE    = 3,
  parameter int pINPUT_CHANNEL  = 1,
  parameter int pINPUT_PARALLEL = 1,
  parameter int pPIPE_LAT       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        win_valid,
  output logic        win_ready,
  output logic        load,
  output logic        buf_en,
  output logic [((pKERNEL_SIZE*pKERNEL_SIZE) > 1 ? $clog2(pKERNEL_SIZE*pKERNEL_SIZE) : 1)-1:0] pixel,
  output logic [((pINPUT_CHANNEL/pINPUT_PARALLEL) > 1 ? $clog2(pINPUT_CHANNEL/pINPUT_PARALLEL) : 1)-1:0] chgrp,
  output logic        mac_first,
  output logic        mac_last,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic [31:0] perf_stall_cnt
);

  localparam int KK    = pKERNEL_SIZE * pKERNEL_SIZE;
  localparam int G     = pINPUT_CHANNEL / pINPUT_PARALLEL;
  localparam int PIX_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int GRP_W = (G > 1) ? $clog2(G) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(KK - 1);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(G - 1);
  localparam logic [GRP_W-1:0] GRP_ONE  = GRP_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                 state_r, nxt_state_s;
  logic [PIX_W-1:0]       pixel_r, nxt_pixel_s;
  logic [GRP_W-1:0]       chgrp_r, nxt_chgrp_s;
  logic                   win_ready_r, load_r, buf_en_r, result_valid_r, busy_r;
  logic                   first_iss_r, last_iss_r;
  logic                   first_iss_s, last_iss_s;
  logic [pPIPE_LAT-1:0]   first_sr_r, last_sr_r;
  logic                   mac_last_s;

  assign mac_last_s = last_sr_r[pPIPE_LAT-1];

  // Next-state and sweep counters; pixel is the inner loop, chgrp the outer.
  always_comb begin
    nxt_state_s = state_r;
    nxt_pixel_s = {PIX_W{1'b0}};
    nxt_chgrp_s = {GRP_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (win_valid && win_ready_r) begin
          nxt_state_s = ST_LOAD;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        nxt_state_s = ST_RUN;
      end
      ST_RUN: begin
        if (pixel_r == PIX_LAST) begin
          if (chgrp_r == GRP_LAST) begin
            nxt_state_s = ST_DRAIN;
          end else begin
            nxt_state_s = ST_RUN;
            nxt_chgrp_s = chgrp_r + GRP_ONE;
          end
        end else begin
          nxt_state_s = ST_RUN;
          nxt_pixel_s = pixel_r + PIX_ONE;
          nxt_chgrp_s = chgrp_r;
        end
      end
      ST_DRAIN: begin
        if (mac_last_s) begin
          nxt_state_s = ST_DONE;
        end else begin
          nxt_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_DONE;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // Issue markers for the beat about to be driven; a single-beat window sets both.
  always_comb begin
    first_iss_s = (state_r == ST_LOAD);
    last_iss_s  = (nxt_state_s == ST_RUN) && (nxt_pixel_s == PIX_LAST) && (nxt_chgrp_s == GRP_LAST);
  end

  // State, counters and all outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      pixel_r        <= {PIX_W{1'b0}};
      chgrp_r        <= {GRP_W{1'b0}};
      win_ready_r    <= 1'b1;
      load_r         <= 1'b0;
      buf_en_r       <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      first_iss_r    <= 1'b0;
      last_iss_r     <= 1'b0;
    end else begin
      state_r        <= nxt_state_s;
      pixel_r        <= nxt_pixel_s;
      chgrp_r        <= nxt_chgrp_s;
      win_ready_r    <= (nxt_state_s == ST_IDLE);
      load_r         <= (nxt_state_s == ST_LOAD);
      buf_en_r       <= (nxt_state_s == ST_RUN);
      result_valid_r <= (nxt_state_s == ST_DONE);
      busy_r         <= (nxt_state_s != ST_IDLE);
      first_iss_r    <= first_iss_s;
      last_iss_r     <= last_iss_s;
    end
  end

  // Delay the issue markers by the buffer read latency so they line up with buffer valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_sr_r <= {pPIPE_LAT{1'b0}};
      last_sr_r  <= {pPIPE_LAT{1'b0}};
    end else begin
      first_sr_r[0] <= first_iss_r;
      last_sr_r[0]  <= last_iss_r;
      for (int i = 1; i < pPIPE_LAT; i++) begin
        first_sr_r[i] <= first_sr_r[i-1];
        last_sr_r[i]  <= last_sr_r[i-1];
      end
    end
  end

  assign win_ready    = win_ready_r;
  assign load         = load_r;
  assign buf_en       = buf_en_r;
  assign pixel        = pixel_r;
  assign chgrp        = chgrp_r;
  assign mac_first    = first_sr_r[pPIPE_LAT-1];
  assign mac_last     = mac_last_s;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;

`ifdef PE_CONV_MAC_SCHED_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles the result sits unaccepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == ST_DONE) && !result_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pe_conv_mac_sched.sv
// Directed bench for pe_conv_mac_sched: default config, two channel groups, and a single-pixel kernel.
module tb_pe_conv_mac_sched;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Instance a: K=3, G=1, LAT=2
  logic        a_win_valid, a_win_ready, a_load, a_buf_en, a_mac_first, a_mac_last;
  logic        a_result_valid, a_result_ready, a_busy;
  logic [3:0]  a_pixel;
  logic [0:0]  a_chgrp;
  logic [31:0] a_perf;

  // Instance b: K=3, C=4, P=2 -> G=2
  logic        b_win_valid, b_win_ready, b_load, b_buf_en, b_mac_first, b_mac_last;
  logic        b_result_valid, b_result_ready, b_busy;
  logic [3:0]  b_pixel;
  logic [0:0]  b_chgrp;
  logic [31:0] b_perf;

  // Instance c: K=1, G=1 -> T=1
  logic        c_win_valid, c_win_ready, c_load, c_buf_en, c_mac_first, c_mac_last;
  logic        c_result_valid, c_result_ready, c_busy;
  logic [0:0]  c_pixel;
  logic [0:0]  c_chgrp;
  logic [31:0] c_perf;

  pe_conv_mac_sched #(.pKERNEL_SIZE(3), .pINPUT_CHANNEL(1), .pINPUT_PARALLEL(1), .pPIPE_LAT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .win_valid(a_win_valid), .win_ready(a_win_ready), .load(a_load),
    .buf_en(a_buf_en), .pixel(a_pixel), .chgrp(a_chgrp), .mac_first(a_mac_first), .mac_last(a_mac_last),
    .result_valid(a_result_valid), .result_ready(a_result_ready), .busy(a_busy), .perf_stall_cnt(a_perf));

  pe_conv_mac_sched #(.pKERNEL_SIZE(3), .pINPUT_CHANNEL(4), .pINPUT_PARALLEL(2), .pPIPE_LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .win_valid(b_win_valid), .win_ready(b_win_ready), .load(b_load),
    .buf_en(b_buf_en), .pixel(b_pixel), .chgrp(b_chgrp), .mac_first(b_mac_first), .mac_last(b_mac_last),
    .result_valid(b_result_valid), .result_ready(b_result_ready), .busy(b_busy), .perf_stall_cnt(b_perf));

  pe_conv_mac_sched #(.pKERNEL_SIZE(1), .pINPUT_CHANNEL(1), .pINPUT_PARALLEL(1), .pPIPE_LAT(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .win_valid(c_win_valid), .win_ready(c_win_ready), .load(c_load),
    .buf_en(c_buf_en), .pixel(c_pixel), .chgrp(c_chgrp), .mac_first(c_mac_first), .mac_last(c_mac_last),
    .result_valid(c_result_valid), .result_ready(c_result_ready), .busy(c_busy), .perf_stall_cnt(c_perf));

  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    a_win_valid = 1'b0; b_win_valid = 1'b0; c_win_valid = 1'b0;
    a_result_ready = 1'b1; b_result_ready = 1'b1; c_result_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      obs = {a_load, a_buf_en, a_mac_first, a_mac_last, a_result_valid, a_win_ready, a_busy};
      n_tests++; if (obs !== 7'b0000010) begin n_fail++; $display("FAIL reset_a_flags phase=%0d got %b want 0000010", p, obs); end
      obs = {b_load, b_buf_en, b_mac_first, b_mac_last, b_result_valid, b_win_ready, b_busy};
      n_tests++; if (obs !== 7'b0000010) begin n_fail++; $display("FAIL reset_b_flags phase=%0d got %b want 0000010", p, obs); end
      obs = {c_load, c_buf_en, c_mac_first, c_mac_last, c_result_valid, c_win_ready, c_busy};
      n_tests++; if (obs !== 7'b0000010) begin n_fail++; $display("FAIL reset_c_flags phase=%0d got %b want 0000010", p, obs); end
      n_tests++; if ({a_pixel, a_chgrp, b_pixel, b_chgrp, c_pixel, c_chgrp} !== 11'd0) begin
        n_fail++; $display("FAIL reset_counters phase=%0d got %h want 0", p, {a_pixel, a_chgrp, b_pixel, b_chgrp, c_pixel, c_chgrp});
      end
      n_tests++; if ((a_perf | b_perf | c_perf) !== 32'd0) begin n_fail++; $display("FAIL reset_perf phase=%0d got %0d want 0", p, a_perf | b_perf | c_perf); end
      if (p == 0) begin
        rst_n = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_single();
    logic [6:0] obs, exp_f;
    logic [3:0] exp_pix;
    a_win_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      obs   = {a_load, a_buf_en, a_mac_first, a_mac_last, a_result_valid, a_win_ready, a_busy};
      exp_f = {k == 1, (k >= 2) && (k <= 10), k == 4, k == 12, k == 13, (k == 0) || (k >= 14), (k >= 1) && (k <= 13)};
      exp_pix = ((k >= 2) && (k <= 10)) ? 4'(k - 2) : 4'd0;
      n_tests++; if (obs !== exp_f) begin n_fail++; $display("FAIL single_flags k=%0d got %b want %b", k, obs, exp_f); end
      n_tests++; if (a_pixel !== exp_pix) begin n_fail++; $display("FAIL single_pixel k=%0d got %0d want %0d", k, a_pixel, exp_pix); end
      @(negedge clk);
      if (k == 0) a_win_valid = 1'b0;
    end
  endtask

  task automatic test_groups();
    logic [6:0] obs, exp_f;
    logic [3:0] exp_pix;
    logic [0:0] exp_grp;
    int n_en = 0, n_first = 0, n_last = 0;
    b_win_valid = 1'b1;
    for (int k = 0; k < 25; k++) begin
      obs   = {b_load, b_buf_en, b_mac_first, b_mac_last, b_result_valid, b_win_ready, b_busy};
      exp_f = {k == 1, (k >= 2) && (k <= 19), k == 4, k == 21, k == 22, (k == 0) || (k >= 23), (k >= 1) && (k <= 22)};
      exp_pix = ((k >= 2) && (k <= 19)) ? 4'((k - 2) % 9) : 4'd0;
      exp_grp = ((k >= 2) && (k <= 19)) ? 1'((k - 2) / 9) : 1'b0;
      n_tests++; if (obs !== exp_f) begin n_fail++; $display("FAIL group_flags k=%0d got %b want %b", k, obs, exp_f); end
      n_tests++; if ({b_pixel, b_chgrp} !== {exp_pix, exp_grp}) begin
        n_fail++; $display("FAIL group_sel k=%0d got pix=%0d grp=%0d want pix=%0d grp=%0d", k, b_pixel, b_chgrp, exp_pix, exp_grp);
      end
      n_en    += int'(b_buf_en);
      n_first += int'(b_mac_first);
      n_last  += int'(b_mac_last);
      @(negedge clk);
      if (k == 0) b_win_valid = 1'b0;
    end
    n_tests++; if (n_en != 18) begin n_fail++; $display("FAIL group_beats got %0d want 18", n_en); end
    n_tests++; if ((n_first != 1) || (n_last != 1)) begin n_fail++; $display("FAIL group_markers got first=%0d last=%0d want 1/1", n_first, n_last); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_perf;
    a_result_ready = 1'b0;
    a_win_valid    = 1'b1;
    for (int k = 0; k < 21; k++) begin
      n_tests++; if ({a_result_valid, a_win_ready} !== {(k >= 13) && (k <= 18), (k == 0) || (k >= 19)}) begin
        n_fail++; $display("FAIL stall_hold k=%0d got rv=%b wr=%b want rv=%b wr=%b", k, a_result_valid, a_win_ready,
                           (k >= 13) && (k <= 18), (k == 0) || (k >= 19));
      end
      @(negedge clk);
      if (k == 0) a_win_valid = 1'b0;
      if (k == 17) a_result_ready = 1'b1;
    end
`ifdef PE_CONV_MAC_SCHED_PERF_EN
    exp_perf = 32'd5;
`else
    exp_perf = 32'd0;
`endif
    n_tests++; if (a_perf !== exp_perf) begin n_fail++; $display("FAIL stall_perf got %0d want %0d", a_perf, exp_perf); end
  endtask

  task automatic test_single_pixel();
    logic [6:0] obs, exp_f;
    c_win_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      obs   = {c_load, c_buf_en, c_mac_first, c_mac_last, c_result_valid, c_win_ready, c_busy};
      exp_f = {k == 1, k == 2, k == 4, k == 4, k == 5, (k == 0) || (k >= 6), (k >= 1) && (k <= 5)};
      n_tests++; if (obs !== exp_f) begin n_fail++; $display("FAIL k1_flags k=%0d got %b want %b", k, obs, exp_f); end
      n_tests++; if ({c_pixel, c_chgrp} !== 2'b00) begin n_fail++; $display("FAIL k1_sel k=%0d got %b want 00", k, {c_pixel, c_chgrp}); end
      @(negedge clk);
      if (k == 0) c_win_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int   n_acc = 0;
    logic open_w = 1'b0;
    a_win_valid = 1'b1;
    for (int k = 0; k < 42; k++) begin
      n_tests++; if ({a_win_ready, a_mac_first, a_mac_last} !== {(k % 14) == 0, (k % 14) == 4, (k % 14) == 12}) begin
        n_fail++; $display("FAIL b2b_timing k=%0d got wr/mf/ml=%b%b%b", k, a_win_ready, a_mac_first, a_mac_last);
      end
      if (a_mac_first) begin
        n_tests++; if (open_w) begin n_fail++; $display("FAIL b2b_interleave k=%0d got first while open want closed", k); end
        open_w = 1'b1;
      end
      if (a_mac_last) begin
        n_tests++; if (!open_w) begin n_fail++; $display("FAIL b2b_orphan_last k=%0d got last while closed want open", k); end
        open_w = 1'b0;
      end
      n_acc += int'(a_win_valid && a_win_ready);
      @(negedge clk);
    end
    a_win_valid = 1'b0;
    n_tests++; if (n_acc != 3) begin n_fail++; $display("FAIL b2b_accepts got %0d want 3", n_acc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [6:0] obs;
    a_win_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) a_win_valid = 1'b0;
    end
    n_tests++; if ({a_buf_en, a_pixel} !== {1'b1, 4'd4}) begin n_fail++; $display("FAIL rstmid_pre got en=%b pix=%0d want en=1 pix=4", a_buf_en, a_pixel); end
    rst_n = 1'b0;
    #1;
    obs = {a_load, a_buf_en, a_mac_first, a_mac_last, a_result_valid, a_win_ready, a_busy};
    n_tests++; if (obs !== 7'b0000010) begin n_fail++; $display("FAIL rstmid_async got %b want 0000010", obs); end
    n_tests++; if (a_pixel !== 4'd0) begin n_fail++; $display("FAIL rstmid_pixel got %0d want 0", a_pixel); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      obs = {a_load, a_buf_en, a_mac_first, a_mac_last, a_result_valid, a_win_ready, a_busy};
      n_tests++; if (obs !== 7'b0000010) begin n_fail++; $display("FAIL rstmid_after k=%0d got %b want 0000010", k, obs); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_groups();
    test_stall();
    test_single_pixel();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
